mem_stage_ctrl: RTL and testbench

//  MEM-stage controller for the dual-issue pipeline, between EX/MEM and the dual-port data memory.
//  Per lane: drives the active-low memory strobes, address and store data; captures load data.

---
 rtl/mem_stage_ctrl_if.sv | 48 ++++
 rtl/mem_stage_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_ctrl_if.sv
// EX/MEM -> data memory -> MEM/WB bundle for the dual-issue MEM stage.
// The master side is the upstream pipeline plus the memory. The slave side is the controller.
interface mem_stage_ctrl_if #(
    parameter int DW    = 32,
    parameter int RW    = 5,
    parameter int CNT_W = 16
);
    logic          ex_valid_1, ex_ld_1, ex_st_1;
    logic [DW-1:0] ex_alu_1, ex_sdata_1;
    logic [RW-1:0] ex_rd_1;
    logic          ex_valid_2, ex_ld_2, ex_st_2;
    logic [DW-1:0] ex_alu_2, ex_sdata_2;
    logic [RW-1:0] ex_rd_2;

    logic             stall;
    logic             Mem_rd_1, Mem_wr_1, Mem_rd_2, Mem_wr_2;
    logic [DW-1:0]    Dir_Mem_1, Dato_Mem_in_1, Dato_Mem_out_1;
    logic [DW-1:0]    Dir_Mem_2, Dato_Mem_in_2, Dato_Mem_out_2;
    logic             wb_valid_1, wb_wen_1, wb_err_1;
    logic [DW-1:0]    wb_data_1;
    logic [RW-1:0]    wb_rd_1;
    logic             wb_valid_2, wb_wen_2, wb_err_2;
    logic [DW-1:0]    wb_data_2;
    logic [RW-1:0]    wb_rd_2;
    logic [CNT_W-1:0] conf_cnt;

    modport master (
        output ex_valid_1, ex_ld_1, ex_st_1, ex_alu_1, ex_sdata_1, ex_rd_1,
        output ex_valid_2, ex_ld_2, ex_st_2, ex_alu_2, ex_sdata_2, ex_rd_2,
        output Dato_Mem_out_1, Dato_Mem_out_2,
        input  stall, Mem_rd_1, Mem_wr_1, Mem_rd_2, Mem_wr_2,
        input  Dir_Mem_1, Dato_Mem_in_1, Dir_Mem_2, Dato_Mem_in_2,
        input  wb_valid_1, wb_wen_1, wb_err_1, wb_data_1, wb_rd_1,
        input  wb_valid_2, wb_wen_2, wb_err_2, wb_data_2, wb_rd_2,
        input  conf_cnt
    );

    modport slave (
        input  ex_valid_1, ex_ld_1, ex_st_1, ex_alu_1, ex_sdata_1, ex_rd_1,
        input  ex_valid_2, ex_ld_2, ex_st_2, ex_alu_2, ex_sdata_2, ex_rd_2,
        input  Dato_Mem_out_1, Dato_Mem_out_2,
        output stall, Mem_rd_1, Mem_wr_1, Mem_rd_2, Mem_wr_2,
        output Dir_Mem_1, Dato_Mem_in_1, Dir_Mem_2, Dato_Mem_in_2,
        output wb_valid_1, wb_wen_1, wb_err_1, wb_data_1, wb_rd_1,
        output wb_valid_2, wb_wen_2, wb_err_2, wb_data_2, wb_rd_2,
        output conf_cnt
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Dual-issue MEM stage: per-lane memory strobes and MEM/WB registers.
// Same-address hazards with a store are split into two cycles, lane 1 first.
module mem_stage_lane #(
    parameter int            DW        = 32,
    parameter int            RW        = 5,
    parameter logic [DW-1:0] MEM_BASE  = 32'h1000_0000,
    parameter int            MEM_WORDS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid,
    input  logic          ld,
    input  logic          st,
    input  logic [DW-1:0] alu,
    input  logic [DW-1:0] sdata,
    input  logic [RW-1:0] rd,
    input  logic [DW-1:0] dout,
    output logic          rd_n,
    output logic          wr_n,
    output logic [DW-1:0] addr,
    output logic [DW-1:0] din,
    output logic          wb_valid,
    output logic          wb_wen,
    output logic          wb_err,
    output logic [DW-1:0] wb_data,
    output logic [RW-1:0] wb_rd
);
    logic in_range, err, ld_ok, st_ok;

    assign in_range = (alu >= MEM_BASE) && ((alu - MEM_BASE) < DW'(MEM_WORDS));
    assign err      = valid & ((((ld | st) & ~in_range)) | (ld & st));
    assign ld_ok    = valid & ld & ~err;
    assign st_ok    = valid & st & ~err;

    // Reset forces the memory side idle, whatever the issue logic presents.
    assign rd_n = ~(rst & ld_ok);
    assign wr_n = ~(rst & st_ok);
    assign addr = (rst & valid)      ? alu   : '0;
    assign din  = (rst & valid & st) ? sdata : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_valid <= 1'b0;
            wb_wen   <= 1'b0;
            wb_err   <= 1'b0;
            wb_data  <= '0;
            wb_rd    <= '0;
        end else begin
            wb_valid <= valid;
            wb_wen   <= valid & ~st & ~err;
            wb_err   <= err;
            wb_data  <= ld_ok ? dout : alu;
            wb_rd    <= rd;
        end
    end
endmodule

module mem_stage_ctrl #(
    parameter int            DW        = 32,
    parameter int            RW        = 5,
    parameter logic [DW-1:0] MEM_BASE  = 32'h1000_0000,
    parameter int            MEM_WORDS = 4,
    parameter int            CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    mem_stage_ctrl_if.slave   bus
);
    localparam int NUM_LANES = 2;

    typedef struct packed {
        logic          valid;
        logic          ld;
        logic          st;
        logic [DW-1:0] alu;
        logic [DW-1:0] sdata;
        logic [RW-1:0] rd;
    } mem_op_t;

    typedef enum logic {RUN, SECOND} state_t;

    state_t                          state_q;
    mem_op_t                         hold_q;
    mem_op_t [NUM_LANES-1:0]         ex_op, iss_op;
    logic                            conflict;
    logic [CNT_W-1:0]                cnt_q;
    logic                            stall_q;

    logic [NUM_LANES-1:0][DW-1:0]    dout, addr, din, wb_data;
    logic [NUM_LANES-1:0][RW-1:0]    wb_rd;
    logic [NUM_LANES-1:0]            rd_n, wr_n, wb_valid, wb_wen, wb_err;

    assign ex_op[0] = '{valid: bus.ex_valid_1, ld: bus.ex_ld_1, st: bus.ex_st_1,
                        alu: bus.ex_alu_1, sdata: bus.ex_sdata_1, rd: bus.ex_rd_1};
    assign ex_op[1] = '{valid: bus.ex_valid_2, ld: bus.ex_ld_2, st: bus.ex_st_2,
                        alu: bus.ex_alu_2, sdata: bus.ex_sdata_2, rd: bus.ex_rd_2};

    // Two loads to the same word are harmless; only a store makes the order matter.
    assign conflict = ex_op[0].valid & ex_op[1].valid
                    & (ex_op[0].ld | ex_op[0].st) & (ex_op[1].ld | ex_op[1].st)
                    & (ex_op[0].alu == ex_op[1].alu)
                    & (ex_op[0].st | ex_op[1].st);

    always_comb begin
        iss_op = ex_op;
        if (state_q == SECOND) begin
            iss_op[0] = '0;
            iss_op[1] = hold_q;
        end else if (conflict) begin
            iss_op[1] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            hold_q  <= '0;
            stall_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (conflict) begin
                        state_q <= SECOND;
                        hold_q  <= ex_op[1];
                        stall_q <= 1'b1;
                    end
                end
                SECOND: begin
                    state_q <= RUN;
                    hold_q  <= '0;
                    stall_q <= 1'b0;
                    if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
                end
                default: begin
                    state_q <= RUN;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    assign dout[0] = bus.Dato_Mem_out_1;
    assign dout[1] = bus.Dato_Mem_out_2;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        mem_stage_lane #(
            .DW(DW), .RW(RW), .MEM_BASE(MEM_BASE), .MEM_WORDS(MEM_WORDS)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .valid    (iss_op[i].valid),
            .ld       (iss_op[i].ld),
            .st       (iss_op[i].st),
            .alu      (iss_op[i].alu),
            .sdata    (iss_op[i].sdata),
            .rd       (iss_op[i].rd),
            .dout     (dout[i]),
            .rd_n     (rd_n[i]),
            .wr_n     (wr_n[i]),
            .addr     (addr[i]),
            .din      (din[i]),
            .wb_valid (wb_valid[i]),
            .wb_wen   (wb_wen[i]),
            .wb_err   (wb_err[i]),
            .wb_data  (wb_data[i]),
            .wb_rd    (wb_rd[i])
        );
    end

    assign bus.stall          = stall_q;
    assign bus.conf_cnt       = cnt_q;
    assign bus.Mem_rd_1       = rd_n[0];
    assign bus.Mem_wr_1       = wr_n[0];
    assign bus.Dir_Mem_1      = addr[0];
    assign bus.Dato_Mem_in_1  = din[0];
    assign bus.Mem_rd_2       = rd_n[1];
    assign bus.Mem_wr_2       = wr_n[1];
    assign bus.Dir_Mem_2      = addr[1];
    assign bus.Dato_Mem_in_2  = din[1];
    assign bus.wb_valid_1     = wb_valid[0];
    assign bus.wb_wen_1       = wb_wen[0];
    assign bus.wb_err_1       = wb_err[0];
    assign bus.wb_data_1      = wb_data[0];
    assign bus.wb_rd_1        = wb_rd[0];
    assign bus.wb_valid_2     = wb_valid[1];
    assign bus.wb_wen_2       = wb_wen[1];
    assign bus.wb_err_2       = wb_err[1];
    assign bus.wb_data_2      = wb_data[1];
    assign bus.wb_rd_2        = wb_rd[1];
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: a vector table for single-cycle bundles,
// plus hand-written conflict, reset-in-SECOND and counter saturation sequences.
module tb_mem_stage_ctrl;
    localparam int          DW   = 32;
    localparam int          RW   = 5;
    localparam int          CW   = 2;
    localparam logic [31:0] BASE = 32'h1000_0000;

    typedef struct packed {
        logic        v, ld, st;
        logic [31:0] alu, sd;
        logic [4:0]  rd;
    } lane_t;

    typedef struct {
        lane_t       l1, l2;
        logic [3:0]  strb;   // {Mem_rd_1, Mem_wr_1, Mem_rd_2, Mem_wr_2}
        logic [2:0]  w1, w2; // {wb_valid, wb_wen, wb_err}
        logic [31:0] d1, d2;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_init = 1'b1;
    logic [31:0] mem [4];
    always #5 clk = ~clk;

    mem_stage_ctrl_if #(.DW(DW), .RW(RW), .CNT_W(CW)) bus ();
    mem_stage_ctrl #(.DW(DW), .RW(RW), .MEM_BASE(BASE), .MEM_WORDS(4), .CNT_W(CW))
        dut (.clk(clk), .rst(rst), .bus(bus));

    // Data memory model: combinational read, write on the clock edge, lane 2 after lane 1.
    assign bus.Dato_Mem_out_1 = mem[bus.Dir_Mem_1[1:0]];
    assign bus.Dato_Mem_out_2 = mem[bus.Dir_Mem_2[1:0]];
    always @(posedge clk) begin
        if (mem_init) begin
            mem[0] <= 32'h10; mem[1] <= 32'h21; mem[2] <= 32'h32; mem[3] <= 32'h02;
        end else begin
            if (!bus.Mem_wr_1) mem[bus.Dir_Mem_1[1:0]] <= bus.Dato_Mem_in_1;
            if (!bus.Mem_wr_2) mem[bus.Dir_Mem_2[1:0]] <= bus.Dato_Mem_in_2;
        end
    end

    int checks = 0;
    int errors = 0;
    vec_t vecs [8];
    int exp_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic lane_t L(input logic v, ld, st, input logic [31:0] alu, sd,
                                input logic [4:0] rd);
        return '{v: v, ld: ld, st: st, alu: alu, sd: sd, rd: rd};
    endfunction

    task automatic set_ex(input lane_t a, input lane_t b);
        bus.ex_valid_1 = a.v; bus.ex_ld_1 = a.ld; bus.ex_st_1 = a.st;
        bus.ex_alu_1 = a.alu; bus.ex_sdata_1 = a.sd; bus.ex_rd_1 = a.rd;
        bus.ex_valid_2 = b.v; bus.ex_ld_2 = b.ld; bus.ex_st_2 = b.st;
        bus.ex_alu_2 = b.alu; bus.ex_sdata_2 = b.sd; bus.ex_rd_2 = b.rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] strb();
        return {bus.Mem_rd_1, bus.Mem_wr_1, bus.Mem_rd_2, bus.Mem_wr_2};
    endfunction

    function automatic logic [2:0] wb1();
        return {bus.wb_valid_1, bus.wb_wen_1, bus.wb_err_1};
    endfunction

    function automatic logic [2:0] wb2();
        return {bus.wb_valid_2, bus.wb_wen_2, bus.wb_err_2};
    endfunction

    initial begin
        vecs[0] = '{L(1,1,0,BASE+0,0,1), L(1,1,0,BASE+3,0,2), 4'b0101, 3'b110, 3'b110, 32'h10, 32'h02};
        vecs[1] = '{L(1,1,0,32'h2000_0000,0,3), L(1,0,0,32'h5,0,4), 4'b1111, 3'b101, 3'b110,
                    32'h2000_0000, 32'h5};
        vecs[2] = '{L(1,0,1,BASE+2,32'h77,0), L(1,0,1,BASE+3,32'h88,0), 4'b1010, 3'b100, 3'b100,
                    BASE+2, BASE+3};
        vecs[3] = '{L(1,1,0,BASE+2,0,1), L(1,1,0,BASE+3,0,2), 4'b0101, 3'b110, 3'b110, 32'h77, 32'h88};
        vecs[4] = '{L(1,1,1,BASE,32'h5A,5), L(0,1,0,BASE,0,6), 4'b1111, 3'b101, 3'b000, BASE, 32'h0};
        vecs[5] = '{L(1,1,0,BASE+4,0,1), L(1,1,0,32'h0FFF_FFFF,0,2), 4'b1111, 3'b101, 3'b101,
                    BASE+4, 32'h0FFF_FFFF};
        vecs[6] = '{L(0,0,1,BASE+1,32'h11,7), L(1,0,1,BASE+1,32'h55,8), 4'b1110, 3'b000, 3'b100,
                    32'h0, BASE+1};
        vecs[7] = '{L(1,1,0,BASE+1,0,1), L(1,1,0,BASE+1,0,2), 4'b0101, 3'b110, 3'b110, 32'h55, 32'h55};

        // Reset, with a store presented to prove the strobe override.
        set_ex(L(1,0,1,BASE+1,32'hDEAD,1), '0);
        repeat (2) tick();
        chk("rst_stall", 32'(bus.stall), 0);
        chk("rst_strb", 32'(strb()), 32'hF);
        chk("rst_dir1", bus.Dir_Mem_1, 0);
        chk("rst_din1", bus.Dato_Mem_in_1, 0);
        chk("rst_wb", {wb1(), wb2()}, 0);
        chk("rst_wbdata", bus.wb_data_1 | bus.wb_data_2, 0);
        chk("rst_cnt", 32'(bus.conf_cnt), 0);
        set_ex('0, '0);
        rst = 1'b1;
        mem_init = 1'b0;

        for (int i = 0; i < 8; i++) begin
            set_ex(vecs[i].l1, vecs[i].l2);
            #1;
            chk($sformatf("v%0d_strb", i), 32'(strb()), 32'(vecs[i].strb));
            tick();
            chk($sformatf("v%0d_stall", i), 32'(bus.stall), 0);
            chk($sformatf("v%0d_wb1", i), 32'(wb1()), 32'(vecs[i].w1));
            chk($sformatf("v%0d_wb2", i), 32'(wb2()), 32'(vecs[i].w2));
            if (vecs[i].w1[2]) chk($sformatf("v%0d_d1", i), bus.wb_data_1, vecs[i].d1);
            if (vecs[i].w2[2]) chk($sformatf("v%0d_d2", i), bus.wb_data_2, vecs[i].d2);
        end
        chk("v0_rd", 32'(bus.wb_rd_2), 2);

        // Store then load, same word: lane 2 must see the new data a cycle later.
        set_ex(L(1,0,1,BASE+1,32'hAB,9), L(1,1,0,BASE+1,0,10));
        #1;
        chk("raw_strb1", 32'(strb()), 32'hB);
        tick();
        chk("raw_stall1", 32'(bus.stall), 1);
        chk("raw_wb1", 32'(wb1()), 32'b100);
        chk("raw_v2_off", 32'(bus.wb_valid_2), 0);
        set_ex(L(1,0,1,BASE,32'hFF,11), '0);
        #1;
        chk("raw_strb2", 32'(strb()), 32'hD);
        chk("raw_dir2", bus.Dir_Mem_2, BASE+1);
        tick();
        chk("raw_stall2", 32'(bus.stall), 0);
        chk("raw_v1_off", 32'(bus.wb_valid_1), 0);
        chk("raw_wb2", 32'(wb2()), 32'b110);
        chk("raw_d2", bus.wb_data_2, 32'hAB);
        chk("raw_rd2", 32'(bus.wb_rd_2), 10);
        chk("raw_cnt", 32'(bus.conf_cnt), 1);
        chk("raw_ignored", mem[0], 32'h10);

        // Load then store, same word: lane 1 reads the old value.
        set_ex(L(1,1,0,BASE+2,0,12), L(1,0,1,BASE+2,32'h99,13));
        tick();
        chk("war_stall", 32'(bus.stall), 1);
        chk("war_d1", bus.wb_data_1, 32'h77);
        set_ex('0, '0);
        tick();
        chk("war_mem", mem[2], 32'h99);
        chk("war_wb2", 32'(wb2()), 32'b100);
        chk("war_cnt", 32'(bus.conf_cnt), 2);

        // Three more conflicts: the 2-bit counter sticks at 3.
        exp_cnt = 2;
        for (int k = 0; k < 3; k++) begin
            set_ex(L(1,0,1,BASE,32'(k),1), L(1,0,1,BASE,32'(k + 32'h100),2));
            tick();
            set_ex('0, '0);
            tick();
            exp_cnt = (exp_cnt == 3) ? 3 : exp_cnt + 1;
            chk($sformatf("sat%0d_cnt", k), 32'(bus.conf_cnt), 32'(exp_cnt));
            chk($sformatf("sat%0d_mem", k), mem[0], 32'(k + 32'h100));
        end

        // Reset during SECOND drops the held lane-2 store.
        set_ex(L(1,0,1,BASE+3,32'h31,1), L(1,0,1,BASE+3,32'h42,2));
        tick();
        chk("rs_stall", 32'(bus.stall), 1);
        set_ex('0, '0);
        rst = 1'b0;
        #1;
        chk("rs_strb", 32'(strb()), 32'hF);
        tick();
        chk("rs_stall0", 32'(bus.stall), 0);
        chk("rs_wb2", 32'(bus.wb_valid_2), 0);
        chk("rs_cnt", 32'(bus.conf_cnt), 0);
        chk("rs_mem", mem[3], 32'h31);
        rst = 1'b1;
        tick();
        chk("rs_after_stall", 32'(bus.stall), 0);
        chk("rs_after_mem", mem[3], 32'h31);
        chk("rs_after_wb2", 32'(bus.wb_valid_2), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
